amm2amm_2x_clk_sync: RTL and testbench



---
 rtl/amm2amm_2x_clk_sync_pkg.sv | 6 +
 rtl/amm2amm_2x_clk_sync_if.sv | 24 ++
 rtl/amm2amm_2x_clk_sync.sv | 51 +++++
 tb/tb_amm2amm_2x_clk_sync.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/amm2amm_2x_clk_sync_pkg.sv
// amm2amm_2x_clk_sync_pkg: shared widths and FSM states for the 1x-to-2x Avalon-MM bridge
package amm2amm_2x_clk_sync_pkg;
    localparam int DEF_ADDR_W = 32;
    localparam int DEF_DATA_W = 32;
    typedef enum logic [1:0] {IDLE, MREQ, RESP} state_t;
endpackage

// File: rtl/amm2amm_2x_clk_sync_if.sv
// amm_if: single Avalon-MM port bundle; the bridge is the slave on one side and the master on the other
interface amm_if
    import amm2amm_2x_clk_sync_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int BE_W   = DEF_DATA_W / 8
);
    localparam int DATA_W = BE_W * 8;
    logic [ADDR_W-1:0] address;
    logic [BE_W-1:0]   byteenable;
    logic [DATA_W-1:0] writedata;
    logic              read;
    logic              write;
    logic              waitrequest;
    logic [DATA_W-1:0] readdata;
    modport master (
        output address, byteenable, writedata, read, write,
        input  waitrequest, readdata
    );
    modport slave (
        input  address, byteenable, writedata, read, write,
        output waitrequest, readdata
    );
endinterface

// File: rtl/amm2amm_2x_clk_sync.sv
// amm2amm_2x_clk_sync: one-at-a-time Avalon-MM bridge from a 1x-clocked slave port to a 2x-clocked master port
module amm2amm_2x_clk_sync
    import amm2amm_2x_clk_sync_pkg::*;
(
    input  logic  clk,
    input  logic  reset,
    input  logic  s_ce,
    amm_if.slave  s,
    amm_if.master m
);
    state_t state;
    logic   rnw;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            rnw           <= 1'b0;
            m.read        <= 1'b0;
            m.write       <= 1'b0;
            m.address     <= '0;
            m.byteenable  <= '0;
            m.writedata   <= '0;
            s.waitrequest <= 1'b1;
            s.readdata    <= '0;
        end else begin
            case (state)
                IDLE: if (s.read || s.write) begin
                    m.address    <= s.address;
                    m.byteenable <= s.byteenable;
                    m.writedata  <= s.writedata;
                    rnw          <= s.read;
                    m.read       <= s.read;
                    m.write      <= s.write;
                    state        <= MREQ;
                end
                MREQ: if (!m.waitrequest) begin
                    m.read        <= 1'b0;
                    m.write       <= 1'b0;
                    s.readdata    <= rnw ? m.readdata : s.readdata;
                    s.waitrequest <= 1'b0;
                    state         <= RESP;
                end
                // hold the response until a 1x edge so the slow initiator is sure to see it
                RESP: if (s_ce) begin
                    s.waitrequest <= 1'b1;
                    state         <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_amm2amm_2x_clk_sync.sv
// tb_amm2amm_2x_clk_sync: directed table plus random soak against a transaction-level model of the bridge
module tb_amm2amm_2x_clk_sync;
    import amm2amm_2x_clk_sync_pkg::*;
    localparam int AW = DEF_ADDR_W;
    localparam int DW = DEF_DATA_W;
    localparam int BW = DW / 8;
    typedef struct {
        logic          wr;
        logic [AW-1:0] addr;
        logic [BW-1:0] be;
        logic [DW-1:0] wdata;
        logic [DW-1:0] rdata;
        int            stalls;
        int            gap;
        int            exp_lat;
        logic [DW-1:0] exp_rd;
    } vec_t;
    typedef struct {
        logic          wr;
        logic [AW-1:0] addr;
        logic [BW-1:0] be;
        logic [DW-1:0] wdata;
    } cmd_t;
    typedef struct {
        int            launch;
        int            stalls;
        logic [DW-1:0] rdata;
    } obs_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic s_ce = 1'b0;
    amm_if #(AW, BW) s_if ();
    amm_if #(AW, BW) m_if ();

    amm2amm_2x_clk_sync dut (
        .clk   (clk),
        .reset (reset),
        .s_ce  (s_ce),
        .s     (s_if),
        .m     (m_if)
    );

    initial forever #5 clk = ~clk;

    int            checks = 0;
    int            errors = 0;
    int            cyc = 0;
    cmd_t          exp_q[$];
    obs_t          obs_q[$];
    int            fab_stall = 0;
    bit            fab_rand = 1'b0;
    logic [DW-1:0] fab_rdata = '0;
    logic [DW-1:0] last_rd = '0;
    bit            mon_prev = 1'b0;
    int            mon_st = 0;
    int            mon_launch = 0;
    cmd_t          mon_c;
    vec_t          tbl[7];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic summary();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    endtask

    task automatic tick();
        @(posedge clk);
        cyc++;
        #1 s_ce = ~s_ce;
    endtask

    // one 1x period; entered and left just after a 1x edge
    task automatic step1x();
        tick();
        tick();
    endtask

    task automatic reset_checks(input string p);
        chk({p, "_m_read"}, m_if.read, 0);
        chk({p, "_m_write"}, m_if.write, 0);
        chk({p, "_s_waitrequest"}, s_if.waitrequest, 1);
        chk({p, "_s_readdata"}, s_if.readdata, 0);
        chk({p, "_m_address"}, m_if.address, 0);
        chk({p, "_m_byteenable"}, m_if.byteenable, 0);
        chk({p, "_m_writedata"}, m_if.writedata, 0);
    endtask

    task automatic issue(input logic wr, input logic [AW-1:0] addr, input logic [BW-1:0] be,
                         input logic [DW-1:0] wdata, input int gap, output int lat, output logic [DW-1:0] rd);
        int   start;
        logic w;
        obs_t o;
        s_if.read  = 1'b0;
        s_if.write = 1'b0;
        repeat (gap) step1x();
        s_if.read       = !wr;
        s_if.write      = wr;
        s_if.address    = addr;
        s_if.byteenable = be;
        s_if.writedata  = wdata;
        exp_q.push_back('{wr, addr, be, wdata});
        start = cyc;
        lat   = 0;
        rd    = '0;
        do begin
            tick();
            w  = s_if.waitrequest;
            rd = s_if.readdata;
            tick();
            lat++;
        end while (w && lat < 100);
        s_if.read  = 1'b0;
        s_if.write = 1'b0;
        if (w) begin
            checks++;
            errors++;
            $display("FAIL timeout: s_waitrequest still 1 after %0d 1x cycles, required 0", lat);
            summary();
        end
        chk("accept_count", obs_q.size(), 1);
        if (obs_q.size() > 0) begin
            o = obs_q.pop_front();
            obs_q.delete();
            chk("launch_cycle", o.launch, start + 1);
            chk("latency_1x", lat, (o.stalls + 2) / 2 + 1);
            chk("s_readdata", rd, wr ? last_rd : o.rdata);
            if (!wr) last_rd = o.rdata;
        end
    endtask

    // fabric: directed stall counts or ~1/3 random acceptance
    initial forever begin
        @(posedge clk);
        #1;
        if (m_if.read || m_if.write) begin
            if (fab_rand) m_if.waitrequest = ($urandom_range(2) != 0);
            else if (fab_stall > 0) begin
                m_if.waitrequest = 1'b1;
                fab_stall--;
            end else m_if.waitrequest = 1'b0;
            m_if.readdata = fab_rand ? $urandom : fab_rdata;
        end else begin
            m_if.waitrequest = 1'b1;
            m_if.readdata    = $urandom;
        end
    end

    // master-side monitor: every accepted command must match the next one issued
    initial forever begin
        @(negedge clk);
        if (reset) begin
            mon_prev = 1'b0;
            mon_st   = 0;
        end else begin
            if ((m_if.read || m_if.write) && !mon_prev) mon_launch = cyc;
            if ((m_if.read || m_if.write) && m_if.waitrequest) mon_st++;
            if ((m_if.read || m_if.write) && !m_if.waitrequest) begin
                if (exp_q.size() == 0) chk("spurious_strobe", {m_if.read, m_if.write}, 0);
                else begin
                    mon_c = exp_q.pop_front();
                    chk("m_write", m_if.write, mon_c.wr);
                    chk("m_read", m_if.read, !mon_c.wr);
                    chk("m_address", m_if.address, mon_c.addr);
                    chk("m_byteenable", m_if.byteenable, mon_c.be);
                    chk("m_writedata", m_if.writedata, mon_c.wdata);
                end
                obs_q.push_back('{mon_launch, mon_st, m_if.readdata});
                mon_st = 0;
            end
            mon_prev = m_if.read || m_if.write;
        end
    end

    initial begin
        int            lat;
        logic [DW-1:0] rd;
        logic          wr;
        tbl[0] = '{1'b1, 32'h1234_5678, 4'hF, 32'hDEAD_BEEF, 32'h0,         0, 0, 2, 32'h0};
        tbl[1] = '{1'b0, 32'h0000_0100, 4'hF, 32'h0,         32'hA5A5_0001, 3, 1, 3, 32'hA5A5_0001};
        tbl[2] = '{1'b0, 32'h0000_0104, 4'hF, 32'h0,         32'h1111_2222, 1, 0, 2, 32'h1111_2222};
        tbl[3] = '{1'b0, 32'h0000_0108, 4'hF, 32'h0,         32'h3333_4444, 0, 0, 2, 32'h3333_4444};
        tbl[4] = '{1'b1, 32'h0000_0200, 4'hF, 32'h5555_6666, 32'h7777_8888, 2, 0, 3, 32'h3333_4444};
        tbl[5] = '{1'b1, 32'h0000_0203, 4'h3, 32'h9999_AAAA, 32'h0,         4, 1, 4, 32'h3333_4444};
        tbl[6] = '{1'b0, 32'hFFFF_FFFC, 4'h1, 32'h0,         32'hCAFE_F00D, 5, 0, 4, 32'hCAFE_F00D};
        s_if.read       = 1'b0;
        s_if.write      = 1'b0;
        s_if.address    = '0;
        s_if.byteenable = '0;
        s_if.writedata  = '0;
        m_if.waitrequest = 1'b1;
        m_if.readdata    = '0;
        step1x();
        step1x();
        reset_checks("rst");
        reset = 1'b0;

        for (int i = 0; i < 7; i++) begin
            fab_stall = tbl[i].stalls;
            fab_rdata = tbl[i].rdata;
            issue(tbl[i].wr, tbl[i].addr, tbl[i].be, tbl[i].wdata, tbl[i].gap, lat, rd);
            chk($sformatf("tbl%0d_latency", i), lat, tbl[i].exp_lat);
            chk($sformatf("tbl%0d_readdata", i), rd, tbl[i].exp_rd);
        end

        fab_stall       = 1000;
        s_if.read       = 1'b1;
        s_if.address    = 32'h0BAD_0BAD;
        s_if.byteenable = 4'hF;
        step1x();
        step1x();
        chk("mreq_read_held", m_if.read, 1);
        #2 reset = 1'b1;
        #1 reset_checks("midrst");
        s_if.read = 1'b0;
        fab_stall = 0;
        step1x();
        exp_q.delete();
        obs_q.delete();
        last_rd = '0;
        reset   = 1'b0;
        fab_rdata = 32'h600D_F00D;
        issue(1'b0, 32'h0000_0040, 4'hF, 32'h0, 0, lat, rd);
        chk("post_rst_latency", lat, 2);
        chk("post_rst_readdata", rd, 32'h600D_F00D);

        fab_rand = 1'b1;
        for (int i = 0; i < 6000; i++) begin
            wr = 1'($urandom_range(1));
            issue(wr, $urandom, BW'($urandom), $urandom,
                  ($urandom_range(3) == 0) ? $urandom_range(2, 1) : 0, lat, rd);
        end
        chk("soak_leftover_cmds", exp_q.size(), 0);
        summary();
    end
endmodule
